// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON message-block sequencer.
package ascon_pkg;

  localparam int BLK_BYTES = 8;
  localparam int BLK_IDX_W = 4;
  localparam int DATALEN_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_CT = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

  // Byte count of a final block given the low bits of the message length.
  function automatic logic [3:0] tail_size(input logic [2:0] len_lo);
    return (len_lo != 3'd0) ? {1'b0, len_lo} : 4'(BLK_BYTES);
  endfunction

endpackage

// File: rtl/ascon_block_seq_wait_timer.sv
// Saturating wait counter; expired once it has counted LIMIT enabled cycles since clear.
module wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_r;

  // Counter: clear has priority, then count up and hold at the limit.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != W'(LIMIT))) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == W'(LIMIT));

endmodule

// File: rtl/ascon_block_seq.sv
// Walks the message memory one 64-bit block at a time, handing each block to the
// ASCON core and strobing the ciphertext write-back.
module ascon_block_seq
  import ascon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATALEN_W-1:0] datalen,
  input  logic                 core_ready,
  input  logic                 core_ct_valid,
  output logic                 busy,
  output logic [BLK_IDX_W-1:0] blk_idx,
  output logic [3:0]           blocksize,
  output logic                 last_block,
  output logic                 pt_valid,
  output logic                 ct_we,
  output logic                 done,
  output logic                 err
);

  seq_state_t           state_r;
  seq_state_t           norm_s;
  seq_state_t           next_s;
  logic [4:0]           nblk_r;
  logic [2:0]           tail_r;
  logic [BLK_IDX_W-1:0] blk_idx_r;
  logic [3:0]           blocksize_r;
  logic                 last_r;
  logic                 err_r;
  logic [4:0]           start_nblk_s;
  logic                 waiting_s;
  logic                 expired_s;
  logic                 timeout_s;
  logic                 abort_s;
  logic                 timer_clr_s;
  logic                 accept_s;
  logic                 advance_s;

  assign start_nblk_s = {1'b0, datalen[6:3]} + {4'd0, (datalen[2:0] != 3'd0)};
  assign waiting_s    = (state_r == ST_ISSUE) || (state_r == ST_WAIT_CT);
  assign timeout_s    = waiting_s && expired_s;
  assign abort_s      = abort && (state_r != ST_IDLE);
  assign accept_s     = (state_r == ST_IDLE) && start && (start_nblk_s != 5'd0);
  assign advance_s    = (state_r == ST_WRITE) && (next_s == ST_LOAD);

  // Next-state logic: abort beats timeout beats the normal walk.
  always_comb begin
    norm_s      = state_r;
    next_s      = state_r;
    timer_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          norm_s = (start_nblk_s != 5'd0) ? ST_LOAD : ST_DONE;
        end else begin
          norm_s = ST_IDLE;
        end
      end
      ST_LOAD:    norm_s = ST_ISSUE;
      ST_ISSUE:   norm_s = core_ready ? ST_WAIT_CT : ST_ISSUE;
      ST_WAIT_CT: norm_s = core_ct_valid ? ST_WRITE : ST_WAIT_CT;
      ST_WRITE:   norm_s = last_r ? ST_DONE : ST_LOAD;
      ST_DONE:    norm_s = ST_IDLE;
      default:    norm_s = ST_IDLE;
    endcase
    if (abort_s) begin
      next_s = ST_IDLE;
    end else if (timeout_s) begin
      next_s = ST_IDLE;
    end else begin
      next_s = norm_s;
    end
    timer_clr_s = ((next_s == ST_ISSUE) && (state_r != ST_ISSUE)) ||
                  ((next_s == ST_WAIT_CT) && (state_r != ST_WAIT_CT));
  end

  // State register and the one-cycle timeout error flag.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      err_r   <= timeout_s && !abort_s;
    end
  end

  // Block bookkeeping: latched on start, stepped as each block is written back.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      nblk_r      <= 5'd0;
      tail_r      <= 3'd0;
      blk_idx_r   <= '0;
      blocksize_r <= 4'd0;
      last_r      <= 1'b0;
    end else if (accept_s) begin
      nblk_r      <= start_nblk_s;
      tail_r      <= datalen[2:0];
      blk_idx_r   <= '0;
      last_r      <= (start_nblk_s == 5'd1);
      blocksize_r <= (start_nblk_s == 5'd1) ? tail_size(datalen[2:0]) : 4'(BLK_BYTES);
    end else if (advance_s) begin
      blk_idx_r   <= blk_idx_r + 4'd1;
      last_r      <= (({1'b0, blk_idx_r} + 5'd2) == nblk_r);
      blocksize_r <= (({1'b0, blk_idx_r} + 5'd2) == nblk_r) ? tail_size(tail_r) : 4'(BLK_BYTES);
    end else begin
      blk_idx_r   <= blk_idx_r;
      last_r      <= last_r;
      blocksize_r <= blocksize_r;
    end
  end

  wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .nRST   (nRST),
    .clr    (timer_clr_s),
    .en     (waiting_s),
    .expired(expired_s)
  );

  assign busy       = (state_r != ST_IDLE);
  assign pt_valid   = (state_r == ST_ISSUE);
  assign ct_we      = (state_r == ST_WRITE);
  assign done       = (state_r == ST_DONE);
  assign err        = err_r;
  assign blk_idx    = blk_idx_r;
  assign blocksize  = blocksize_r;
  assign last_block = last_r;

endmodule
